// File: rtl/rotation_disk.sv
`default_nettype none
// ============================================================================
//  Module   : rotation_disk
//  Purpose  : Rotating disk with a single red mark, held as a one-hot ring
//             register. left/right commands step the mark one position per
//             clock. Two fixed sensors report when the mark passes under
//             them, and their firing order encodes the rotation direction.
//  Ports    : clk      - rising-edge clock (single domain)
//             rst_n    - synchronous, active-low reset
//             left     - rotate-left command (mark moves to higher index)
//             right    - rotate-right command (mark moves to lower index)
//             sensorA  - high while the mark is at SENSOR_A_IDX
//             sensorB  - high while the mark is at SENSOR_B_IDX
//             temp     - one-hot disk position, set bit is the mark
//  Revision : 1.0 - initial release
// ============================================================================
module rotation_disk #(
  parameter int WIDTH        = 32,
  parameter int SENSOR_A_IDX = 1,
  parameter int SENSOR_B_IDX = 0,
  parameter int RESET_IDX    = WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             left,
  input  logic             right,
  output logic             sensorA,
  output logic             sensorB,
  output logic [WIDTH-1:0] temp
);

  localparam logic [WIDTH-1:0] RESET_VALUE = {{(WIDTH-1){1'b0}}, 1'b1} << RESET_IDX;

  // Conflicting commands (both high) fall through to hold, as does idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      temp <= RESET_VALUE;
    end else if (left && !right) begin
      temp <= {temp[WIDTH-2:0], temp[WIDTH-1]};
    end else if (right && !left) begin
      temp <= {temp[0], temp[WIDTH-1:1]};
    end
  end

  // Direct register bits, so the sensor outputs cannot glitch.
  assign sensorA = temp[SENSOR_A_IDX];
  assign sensorB = temp[SENSOR_B_IDX];

endmodule
`default_nettype wire

// File: tb/tb_rotation_disk.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rotation_disk
//  Purpose  : Self-checking bench for rotation_disk. The reference model keeps
//             the mark as an integer position and derives temp/sensors from it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rotation_disk;

  localparam int WIDTH = 32;
  localparam int A_IDX = 1;
  localparam int B_IDX = 0;
  localparam int R_IDX = WIDTH - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             left = 1'b0;
  logic             right = 1'b0;
  logic             sensorA;
  logic             sensorB;
  logic [WIDTH-1:0] temp;

  int checks = 0;
  int errors = 0;
  int pos = R_IDX;   // model: index of the red mark

  rotation_disk #(
    .WIDTH(WIDTH), .SENSOR_A_IDX(A_IDX), .SENSOR_B_IDX(B_IDX), .RESET_IDX(R_IDX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right),
    .sensorA(sensorA), .sensorB(sensorB), .temp(temp)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model_temp(input int p);
    logic [WIDTH-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Drive one cycle of stimulus, advance the model, sample 1 time unit later.
  task automatic step(input logic rn, input logic l, input logic r);
    rst_n = rn;
    left  = l;
    right = r;
    @(posedge clk);
    #1;
    if (!rn)            pos = R_IDX;
    else if (l && !r)   pos = (pos + 1) % WIDTH;
    else if (r && !l)   pos = (pos + WIDTH - 1) % WIDTH;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (temp !== 32'h8000_0000 || sensorA !== 1'b0 || sensorB !== 1'b0) begin
        errors++;
        $display("FAIL reset edge%0d: temp=%h A=%b B=%b, expected temp=80000000 A=0 B=0",
                 i, temp, sensorA, sensorB);
      end
    end
  endtask

  task automatic test_right_sweep;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= WIDTH; i++) begin
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (temp !== model_temp(pos) || sensorA !== (pos == A_IDX) || sensorB !== (pos == B_IDX)) begin
        errors++;
        $display("FAIL right_sweep edge%0d: temp=%h A=%b B=%b, expected temp=%h A=%b B=%b",
                 i, temp, sensorA, sensorB, model_temp(pos), pos == A_IDX, pos == B_IDX);
      end
      if (i == 30) begin
        checks++;
        if (temp !== 32'h0000_0002 || sensorA !== 1'b1 || sensorB !== 1'b0) begin
          errors++;
          $display("FAIL right_sweep_30: temp=%h A=%b B=%b, expected 00000002 A=1 B=0", temp, sensorA, sensorB);
        end
      end
      if (i == 31) begin
        checks++;
        if (temp !== 32'h0000_0001 || sensorA !== 1'b0 || sensorB !== 1'b1) begin
          errors++;
          $display("FAIL right_sweep_31: temp=%h A=%b B=%b, expected 00000001 A=0 B=1", temp, sensorA, sensorB);
        end
      end
      if (i == 32) begin
        checks++;
        if (temp !== 32'h8000_0000 || sensorA !== 1'b0 || sensorB !== 1'b0) begin
          errors++;
          $display("FAIL right_sweep_wrap: temp=%h A=%b B=%b, expected 80000000 A=0 B=0", temp, sensorA, sensorB);
        end
      end
    end
  endtask

  task automatic test_left_sweep;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= WIDTH; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (temp !== model_temp(pos) || sensorA !== (pos == A_IDX) || sensorB !== (pos == B_IDX)) begin
        errors++;
        $display("FAIL left_sweep edge%0d: temp=%h A=%b B=%b, expected temp=%h",
                 i, temp, sensorA, sensorB, model_temp(pos));
      end
      if (i == 1) begin
        checks++;
        if (temp !== 32'h0000_0001 || sensorB !== 1'b1) begin
          errors++;
          $display("FAIL left_sweep_1: temp=%h B=%b, expected 00000001 B=1", temp, sensorB);
        end
      end
      if (i == 2) begin
        checks++;
        if (temp !== 32'h0000_0002 || sensorA !== 1'b1) begin
          errors++;
          $display("FAIL left_sweep_2: temp=%h A=%b, expected 00000002 A=1", temp, sensorA);
        end
      end
      if (i == 32) begin
        checks++;
        if (temp !== 32'h8000_0000) begin
          errors++;
          $display("FAIL left_sweep_wrap: temp=%h, expected 80000000", temp);
        end
      end
    end
  endtask

  task automatic test_hold;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i < 5) step(1'b1, 1'b0, 1'b0);
      else       step(1'b1, 1'b1, 1'b1);
      checks++;
      if (temp !== 32'h0000_0004 || sensorA !== 1'b0 || sensorB !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc%0d: temp=%h A=%b B=%b, expected 00000004 A=0 B=0",
                 i, temp, sensorA, sensorB);
      end
    end
  endtask

  task automatic test_reversal;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1);
    checks++;
    if (temp !== 32'h0000_0002 || sensorA !== 1'b1) begin
      errors++;
      $display("FAIL reversal_pre: temp=%h A=%b, expected 00000002 A=1", temp, sensorA);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (temp !== 32'h0000_0004 || sensorA !== 1'b0) begin
      errors++;
      $display("FAIL reversal_post: temp=%h A=%b, expected 00000004 A=0", temp, sensorA);
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 61; i++) begin
        step(1'b1, k[0], ~k[0]);
        checks++;
        if (!$onehot(temp) || temp !== model_temp(pos) || (sensorA && sensorB)) begin
          errors++;
          $display("FAIL reversal_alt k%0d cyc%0d: temp=%h, expected %h", k, i, temp, model_temp(pos));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0);
    checks++;
    if (temp !== 32'h0000_0100) begin
      errors++;
      $display("FAIL reset_mid_pre: temp=%h, expected 00000100", temp);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (temp !== 32'h8000_0000) begin
      errors++;
      $display("FAIL reset_mid_snap: temp=%h, expected 80000000", temp);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (temp !== 32'h0000_0001 || sensorB !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_resume: temp=%h B=%b, expected 00000001 B=1", temp, sensorB);
    end
  endtask

  task automatic test_random;
    logic rn, l, r;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 19) != 0);
      l  = $urandom_range(0, 1) != 0;
      r  = $urandom_range(0, 1) != 0;
      step(rn, l, r);
      checks++;
      if (temp !== model_temp(pos) || sensorA !== (pos == A_IDX) || sensorB !== (pos == B_IDX)) begin
        errors++;
        $display("FAIL random cyc%0d (rn=%b l=%b r=%b): temp=%h A=%b B=%b, expected temp=%h A=%b B=%b",
                 i, rn, l, r, temp, sensorA, sensorB, model_temp(pos), pos == A_IDX, pos == B_IDX);
      end
    end
  endtask

  initial begin
    test_reset();
    test_right_sweep();
    test_left_sweep();
    test_hold();
    test_reversal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
